multi_led_blinker: RTL and testbench
====================================

Name: multi_led_blinker

Overview:
- Parametrised, multi-channel successor to the single-LED blinker.
- A shared prescaler derives a slow tick from the system clock.
- Each channel drives one LED in one of four runtime-selectable modes: OFF, ON, BLINK (programmable half-period in ticks) or PWM (programmable duty, for dimming).
- Channels are configured through a valid/ready write port. The block sits between board-level control logic and the LED pins.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- TICK_HZ, 1_000: prescaler tick rate in Hz. DIV = CLK_HZ/TICK_HZ and must be >= 2.
- NUM_CH, 4: number of LED channels, >= 1.
- CNT_W, 16: width of the blink half-period and the per-channel phase counter.
- PWM_W, 8: width of the PWM duty value and the PWM counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  block can accept a configuration write.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel index.
- cfg_mode  in  2  mode: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
- cfg_period  in  CNT_W  BLINK half-period, in ticks.
- cfg_duty  in  PWM_W  PWM on-count per PWM frame.
- cfg_err  out  1  one-cycle pulse when an accepted write names cfg_ch >= NUM_CH.
- tick  out  1  one-cycle prescaler pulse.
- led  out  NUM_CH  LED outputs, all registered.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All modes OFF; period and duty registers cleared.
  - Prescaler, PWM counter and phase counters cleared.
  - led=0, tick=0, cfg_err=0, cfg_ready=0.
  - Reset asserted mid-operation overrides everything within that cycle, including a simultaneous cfg write.
- First edge after reset is released: cfg_ready=1.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick is registered high for exactly one cycle each time the count equals DIV-1, so tick has period DIV cycles.
  - The first tick occurs DIV cycles after reset release.
- PWM counter: shared, free-running, PWM_W bits, increments every clk and wraps at 2^PWM_W-1 -> 0.
- Handshake:
  - A write is accepted on an edge where cfg_valid && cfg_ready.
  - cfg_ready drops to 0 for the one cycle after each accept, then returns to 1. Back-to-back writes therefore take 2 cycles each.
  - Inputs only need to be stable on the accepting edge.
- Accepted write, valid channel: latch mode, period and duty into that channel, clear its phase counter, and force its BLINK state to 0.
- Accepted write, cfg_ch >= NUM_CH: discarded with no state change; cfg_err pulses high the next cycle.
- Output latency: the new led value appears on the edge after the accepting edge, i.e. led is a registered function of the updated state.
- Modes:
  - OFF: led=0.
  - ON: led=1.
  - BLINK:
    - On each tick, phase increments.
    - When phase == eff_period-1 on a tick, the led toggles and phase clears.
    - eff_period = cfg_period, or 1 when cfg_period==0, so period 0 toggles on every tick.
    - The led starts at 0 and first rises after eff_period ticks.
  - PWM:
    - led = (pwm_cnt < duty), registered.
    - duty=0 gives a constant 0. duty=2^PWM_W-1 gives low for 1 cycle in every 2^PWM_W.
    - Phase counter is unused.
- Simultaneous write and tick to the same channel: the write wins; that tick is ignored for that channel. Other channels process the tick normally.
- Changing mode away from BLINK and back restarts the blink from led=0.
- Channels are fully independent apart from the shared tick and PWM counter.

Test Plan:
- Test configuration: CLK_HZ=1000, TICK_HZ=100 (DIV=10), NUM_CH=4, PWM_W=8.
- Reset/idle: hold reset=0 for 5 cycles, then release -> led=0000 and cfg_ready=1 on the first post-release edge; tick first pulses 10 cycles after release and then every 10 cycles.
- BLINK: write ch0 mode=10, period=5 -> led[0]=0, rises after 5 ticks (50 cycles), falls after a further 50 cycles; period=0 on ch1 -> led[1] toggles every 10 cycles.
- ON/OFF/PWM: ch2 ON -> led[2]=1 one cycle after accept. ch3 PWM duty=64 -> 64 high cycles per 256-cycle frame. duty=0 -> never high.
- Handshake and error: hold cfg_valid high with 3 writes -> accepts on alternate cycles, cfg_ready low in between; cfg_ch=5 -> no LED change and one cfg_err pulse.
- Collisions: rewrite a blinking ch0 on the exact tick cycle -> phase restarts from 0 and the tick has no effect on ch0; assert reset mid-blink alongside a write -> all led=0, the write is lost, and cfg_ready=0 until release.

Source files
------------

// File: rtl/multi_led_blinker.sv
// Multi-channel LED driver: a shared prescaler tick and a free-running PWM counter feed
// per-channel OFF / ON / BLINK / PWM outputs, configured through a valid/ready write port.
module multi_led_blinker #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PWM_W   = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           cfg_valid,
  output logic                                           cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                     cfg_mode,
  input  logic [CNT_W-1:0]                               cfg_period,
  input  logic [PWM_W-1:0]                               cfg_duty,
  output logic                                           cfg_err,
  output logic                                           tick,
  output logic [NUM_CH-1:0]                              led
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  logic [PRE_W-1:0] presc;
  logic [PWM_W-1:0] pwm_cnt;
  mode_t            mode_q     [NUM_CH];
  logic [CNT_W-1:0] period_q   [NUM_CH];
  logic [PWM_W-1:0] duty_q     [NUM_CH];
  logic [CNT_W-1:0] phase_q    [NUM_CH];
  logic [CNT_W-1:0] last_phase [NUM_CH];
  logic [NUM_CH-1:0] blink_q;
  logic accept;
  logic ch_ok;
  logic presc_wrap;

  assign accept     = cfg_valid && cfg_ready;
  assign ch_ok      = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);
  assign presc_wrap = (presc == PRE_W'(DIV - 1));

  // A half-period of 0 behaves like 1, so the blink toggles on every tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      last_phase[i] = (period_q[i] == '0) ? '0 : period_q[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      led       <= '0;
      blink_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        phase_q[i]  <= '0;
      end
    end else begin
      presc     <= presc_wrap ? '0 : presc + PRE_W'(1);
      tick      <= presc_wrap;
      pwm_cnt   <= pwm_cnt + PWM_W'(1);
      cfg_ready <= !accept;
      cfg_err   <= accept && !ch_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        // A write to this channel takes priority over a coincident tick.
        if (accept && (cfg_ch == CH_W'(i))) begin
          mode_q[i]   <= mode_t'(cfg_mode);
          period_q[i] <= cfg_period;
          duty_q[i]   <= cfg_duty;
          phase_q[i]  <= '0;
          blink_q[i]  <= 1'b0;
        end else if (tick && (mode_q[i] == MODE_BLINK)) begin
          if (phase_q[i] == last_phase[i]) begin
            phase_q[i] <= '0;
            blink_q[i] <= ~blink_q[i];
          end else begin
            phase_q[i] <= phase_q[i] + CNT_W'(1);
          end
        end
        unique case (mode_q[i])
          MODE_OFF:   led[i] <= 1'b0;
          MODE_ON:    led[i] <= 1'b1;
          MODE_BLINK: led[i] <= blink_q[i];
          MODE_PWM:   led[i] <= (pwm_cnt < duty_q[i]);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Randomised scoreboard bench for multi_led_blinker; a second 5-channel instance exercises
// the out-of-range channel path.
module tb_multi_led_blinker;

  localparam int DIV = 10;
  localparam int NCH = 4;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        cfg_valid  = 1'b0;
  logic        cfg_valid5 = 1'b0;
  logic [1:0]  cfg_ch     = '0;
  logic [2:0]  cfg_ch5    = '0;
  logic [1:0]  cfg_mode   = '0;
  logic [15:0] cfg_period = '0;
  logic [7:0]  cfg_duty   = '0;
  logic        cfg_ready, cfg_err, tick;
  logic [3:0]  led;
  logic        cfg_ready5, cfg_err5, tick5;
  logic [4:0]  led5;

  multi_led_blinker #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_CH(4), .CNT_W(16), .PWM_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err), .tick(tick), .led(led)
  );

  multi_led_blinker #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_CH(5), .CNT_W(16), .PWM_W(8)) dut5 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
    .cfg_ch(cfg_ch5), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err5), .tick(tick5), .led(led5)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic       tick;
    logic       ready;
    logic       err;
    logic [4:0] led5;
    logic       ready5;
    logic       err5;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: edge index since reset release plus the last accepted config per channel.
  int cyc;
  bit m_ready, m_ready5, m5_on;
  int m_mode[NCH], m_period[NCH], m_duty[NCH], m_acc[NCH];

  // LED value after edge n, from the config accepted at an earlier edge.
  function automatic bit ledAt(int c, int n);
    int eff, t;
    case (m_mode[c])
      0: return 1'b0;
      1: return 1'b1;
      2: begin
        eff = (m_period[c] == 0) ? 1 : m_period[c];
        t   = (n - 1) / DIV - m_acc[c] / DIV;
        return ((t / eff) % 2) == 1;
      end
      default: return (n % 256) < m_duty[c];
    endcase
  endfunction

  task automatic applyStimulus(input bit rst_n, input bit v, input bit v5, input int ch,
                               input int mode, input int period, input int duty,
                               output bit accepted);
    exp_t e;
    bit acc, acc5;
    @(negedge clk);
    reset      = rst_n;
    cfg_valid  = v;
    cfg_valid5 = v5;
    cfg_ch     = 2'(ch);
    cfg_ch5    = 3'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = 16'(period);
    cfg_duty   = 8'(duty);
    accepted   = 1'b0;
    if (!rst_n) begin
      e = '{cyc: -1, led: '0, tick: 1'b0, ready: 1'b0, err: 1'b0,
            led5: '0, ready5: 1'b0, err5: 1'b0};
      cyc = 0; m_ready = 1'b0; m_ready5 = 1'b0; m5_on = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_period[c] = 0; m_duty[c] = 0; m_acc[c] = -1;
      end
    end else begin
      acc  = v && m_ready;
      acc5 = v5 && m_ready5;
      e.cyc   = cyc;
      e.tick  = (cyc % DIV) == DIV - 1;
      for (int c = 0; c < NCH; c++) e.led[c] = ledAt(c, cyc);
      e.ready  = !acc;
      e.err    = 1'b0;
      e.led5   = {m5_on, 4'b0000};
      e.ready5 = !acc5;
      e.err5   = acc5 && (ch >= 5);
      if (acc && ch < NCH) begin
        m_mode[ch] = mode; m_period[ch] = period; m_duty[ch] = duty; m_acc[ch] = cyc;
      end
      if (acc5 && ch == 4 && mode == 1) m5_on = 1'b1;
      m_ready  = !acc;
      m_ready5 = !acc5;
      accepted = acc || acc5;
      cyc++;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, a);
  endtask

  task automatic writeCfg(input int ch, input int mode, input int period, input int duty,
                          input bit to5);
    bit a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 50) begin
      applyStimulus(1'b1, !to5, to5, ch, mode, period, duty, a);
      tries++;
    end
    if (!a) begin
      checks++;
      errors++;
      $display("[TB] FAIL write_timeout ch=%0d got=no_accept exp=accept", ch);
    end
  endtask

  task automatic cmpField(input string name, input int c, input logic [31:0] got,
                          input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField("led",        e.cyc, 32'(led),        32'(e.led));
    cmpField("tick",       e.cyc, 32'(tick),       32'(e.tick));
    cmpField("cfg_ready",  e.cyc, 32'(cfg_ready),  32'(e.ready));
    cmpField("cfg_err",    e.cyc, 32'(cfg_err),    32'(e.err));
    cmpField("led5",       e.cyc, 32'(led5),       32'(e.led5));
    cmpField("tick5",      e.cyc, 32'(tick5),      32'(e.tick));
    cmpField("cfg_ready5", e.cyc, 32'(cfg_ready5), 32'(e.ready5));
    cmpField("cfg_err5",   e.cyc, 32'(cfg_err5),   32'(e.err5));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    bit a;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, a);
    idle(35);
    // Valid stays high across these four writes, so accepts land on alternate edges.
    writeCfg(0, 2, 5, 0, 1'b0);
    writeCfg(1, 2, 0, 0, 1'b0);
    writeCfg(2, 1, 0, 0, 1'b0);
    writeCfg(3, 3, 0, 64, 1'b0);
    idle(300);
    writeCfg(3, 3, 0, 0, 1'b0);
    idle(260);
    writeCfg(5, 1, 0, 0, 1'b1);
    idle(3);
    writeCfg(4, 1, 0, 0, 1'b1);
    idle(5);
    // Land a rewrite of blinking ch0 on an edge where tick is high.
    for (int k = 0; k < 3 * DIV; k++) begin
      if ((cyc % DIV) == 0 && m_ready) break;
      idle(1);
    end
    writeCfg(0, 2, 3, 0, 1'b0);
    idle(100);
    repeat (40) begin
      writeCfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 255)), 1'b0);
      idle(int'($urandom_range(0, 25)));
    end
    writeCfg(0, 2, 4, 0, 1'b0);
    idle(25);
    // Reset mid-blink with a simultaneous write: the write must be lost.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 2, 1, 0, 0, a);
    idle(20);
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
